// File: rtl/instruction_encoder.sv
// Single-stage register encoder: packs RISC-V I/S/B/R fields into a 32-bit
// word, flags unencodable requests (emitted as NOP), and counts consumed
// good and rejected results with saturating counters.
module instruction_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      instruction,
   output logic             err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [6:0]  OP_LOAD = 7'b0000011;
   localparam logic [6:0]  OP_IMM  = 7'b0010011;
   localparam logic [6:0]  OP_ST   = 7'b0100011;
   localparam logic [6:0]  OP_BR   = 7'b1100011;
   localparam logic [6:0]  OP_REG  = 7'b0110011;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic             out_valid_q, out_valid_d;
   logic [31:0]      instr_q, instr_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [31:0] enc_word;
   logic        enc_err;
   logic        fits12, fits13;
   logic        in_hs, out_hs;

   // Sign-extension test: a value fits N signed bits when the bits above
   // N-2 are all copies of the sign bit.
   assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);

   // Field packing and legality check; illegal requests collapse to NOP.
   always_comb begin
      enc_word = NOP;
      enc_err  = 1'b0;
      unique case (opcode)
         OP_LOAD, OP_IMM: begin
            enc_err  = !fits12;
            enc_word = {imm[11:0], rs1, funct3, rd, opcode};
         end
         OP_ST: begin
            enc_err  = !fits12;
            enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         end
         OP_BR: begin
            // 13-bit range is -4096..4095; the odd 4095 is excluded by imm[0].
            enc_err  = !fits13 || imm[0];
            enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         end
         OP_REG: begin
            enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         default: enc_err = 1'b1;
      endcase
      if (enc_err) enc_word = NOP;
   end

   assign in_ready = !out_valid_q || out_ready;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   // Output register next-state: drain on consume, reload on accept, and
   // bump the matching saturating counter for each consumed result.
   always_comb begin
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      err_d       = err_q;
      enc_cnt_d   = enc_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (out_hs) begin
         out_valid_d = 1'b0;
         if (err_q) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
         end else begin
            if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_W'(1);
         end
      end
      if (in_hs) begin
         out_valid_d = 1'b1;
         instr_d     = enc_word;
         err_d       = enc_err;
      end
   end

   // State registers; reset drops any pending result uncounted.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         err_q       <= 1'b0;
         enc_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         err_q       <= err_d;
         enc_cnt_q   <= enc_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign instruction = instr_q;
   assign err         = err_q;
   assign enc_count   = enc_cnt_q;
   assign err_count   = err_cnt_q;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1: request fields valid.
REQ-005 SHALL have port in_ready  output  1: encoder can accept a request this cycle.
REQ-006 SHALL have port opcode  input  7: instruction opcode.
REQ-007 SHALL have ports rd, rs1, rs2  input  5 each: register indices.
REQ-008 SHALL have ports funct3 (input, 3) and funct7 (input, 7): function fields.
REQ-009 SHALL have port imm  input  32: two's-complement immediate.
REQ-010 SHALL have port out_valid  output  1: instruction/err valid.
REQ-011 SHALL have port out_ready  input  1: consumer accepts output.
REQ-012 SHALL have port instruction  output  32: encoded instruction word.
REQ-013 SHALL have port err  output  1: the current output is a rejected request.
REQ-014 SHALL have ports enc_count and err_count  output  CNT_W: accepted-good and accepted-error totals.

Function
REQ-015 SHALL accept a request when in_valid && in_ready (input handshake).
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational), giving one request per cycle under no backpressure.
REQ-017 SHALL register the result on input handshake: out_valid=1 on the next cycle (latency 1).
REQ-018 SHALL clear out_valid on output handshake (out_valid && out_ready) when no new request is accepted that cycle; on simultaneous output and input handshake, SHALL load the new result with out_valid staying 1.
REQ-019 SHALL hold instruction and err stable while out_valid && !out_ready.
REQ-020 SHALL encode opcodes 0000011 and 0010011 (I): {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 SHALL encode opcode 0100011 (S): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 SHALL encode opcode 1100011 (B): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 SHALL encode opcode 0110011 (R): {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
REQ-024 SHALL set err=1 if an I/S immediate lies outside -2048..2047.
REQ-025 SHALL set err=1 if a B immediate lies outside -4096..4094 or imm[0]=1.
REQ-026 SHALL set err=1 for any other opcode.
REQ-027 SHALL output instruction = 32'h00000013 (NOP) whenever err=1.
REQ-028 SHALL guarantee round trip: for err=0 I/S/B results, sign-extended immediate decode of instruction equals imm.
REQ-029 SHALL increment enc_count on output handshake with err=0, and err_count on output handshake with err=1; both saturate at all-ones, never wrap.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set out_valid=0, err=0, instruction=32'h00000000, enc_count=0, err_count=0.
REQ-031 SHALL discard any pending output on reset without counting it; no request is accepted in a reset cycle.
REQ-032 SHALL have in_ready=1 in the first cycle after reset is released.

Verification
REQ-033 SHALL verify I-type: opcode=0x13, rd=1, rs1=2, funct3=0, imm=-1 -> next cycle out_valid=1, instruction=0xFFF10093, err=0.
REQ-034 SHALL verify S/B: opcode=0x23, funct3=2, rs1=2, rs2=5, imm=8 -> 0x00512423; opcode=0x63, funct3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
REQ-035 SHALL verify errors: I imm=2048, B imm=3, opcode=0x7F -> each err=1, instruction=0x00000013; after all consumed, err_count=3, enc_count unchanged.
REQ-036 SHALL verify backpressure: out_ready=0 with in_valid held -> in_ready=0, instruction stable; raise out_ready -> first output consumed and second request accepted in the same cycle.
REQ-037 SHALL verify throughput: out_ready=1, 8 back-to-back valid requests -> 8 consecutive out_valid cycles, enc_count=8.
REQ-038 SHALL verify mid-operation reset: rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, counters=0, in_ready=1.
